mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Sequences one data-memory access per request from the MEM stage: load or store of byte, halfword or word.
- Drives a req/ack word-wide memory port.
- Splits misaligned accesses that cross a word boundary into two beats.
- Forms byte enables and aligned write data; extracts and sign/zero-extends load data.
- Stalls the pipeline while busy and aborts with a fault on memory timeout.

Parameters:
- MAX_WAIT, 15: cycles a beat may wait for mem_ack before abort (1..255).

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  access request, sampled only in IDLE
- rw  in  1  MEM_READ=0 / MEM_WRITE=1
- store_sel  in  2  STORE_W / STORE_H / STORE_B
- load_sel  in  3  funct3: LB=000, LH=001, LW=010, LBU=100, LHU=101
- addr  in  32  byte address
- wdata  in  32  store data, right-justified
- busy  out  1  pipeline stall, high in every non-IDLE state
- done  out  1  one-cycle completion pulse
- fault  out  1  high with done when the access timed out
- rdata  out  32  extended load result, valid while done=1
- mem_req  out  1  memory beat request
- mem_we  out  1  beat is a write
- mem_addr  out  32  word-aligned address, bits[1:0]=0
- mem_wdata  out  32  lane-aligned write data
- mem_be  out  4  byte-lane enables, for reads and writes
- mem_ack  in  1  beat complete, single-cycle, meaningful only while mem_req=1
- mem_rdata  in  32  read word, valid with mem_ack

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE.
  - All outputs 0.
  - Wait counter and latched request cleared.
  - Reset mid-access drops mem_req immediately; no done is produced.
- Every output is registered.
- States and transitions:
  - IDLE:
    - start=1: latch rw, size, sign, addr, wdata; go to BEAT0.
    - Size: rw=1 takes size from store_sel; 2'b11 is treated as word.
    - rw=0 takes size from load_sel; 011, 110, 111 are treated as LW.
  - BEAT0:
    - Outputs: mem_req=1, mem_addr={addr[31:2],2'b00}.
    - Let o=addr[1:0], n=size in bytes (1/2/4). split = o+n>4.
    - mem_ack=1 and split: go to BEAT1.
    - mem_ack=1 and not split: go to IDLE with done=1.
  - BEAT1:
    - Outputs: mem_req=1, mem_addr=word base+4, wrapping modulo 2^32.
    - mem_ack=1: go to IDLE with done=1.
  - mem_req stays high back-to-back from BEAT0 into BEAT1.
  - mem_addr, mem_we, mem_be and mem_wdata are stable while mem_req=1 until ack.
- Lane formation:
  - mask8 = ((1<<n)-1)<<o, 8 bits.
  - data64 = zero-extended wdata << 8*o.
  - BEAT0 uses mask8[3:0] and data64[31:0]; BEAT1 uses mask8[7:4] and data64[63:32].
  - Byte accesses never split.
- Load assembly:
  - BEAT0 rdata is held in a 32-bit register.
  - result = ({beat1, beat0} >> 8*o), truncated to n bytes, then sign-extended (LB, LH) or zero-extended (LBU, LHU).
  - For a store, rdata=0.
- Latency:
  - Request start sampled at edge k puts mem_req high from cycle k+1.
  - An ack in cycle k+1 puts done high in cycle k+2.
  - Each extra wait cycle or second beat adds one cycle.
- Timeout:
  - The counter clears at each beat start and counts cycles with mem_req=1 and mem_ack=0.
  - When the counter reaches MAX_WAIT: drop mem_req, go to IDLE, done=1, fault=1, rdata=0.
  - A partial write on a split store is not rolled back.
- Simultaneous and ignored events:
  - start while busy is ignored; the pipeline must hold it.
  - start in the cycle done=1 is accepted, since the state is IDLE.
  - mem_ack while mem_req=0 is ignored.
  - mem_ack in the same cycle the counter reaches MAX_WAIT counts as success.

Decomposition:
- Shared codes package holds:
  - MEM_READ, MEM_WRITE.
  - STORE_W, STORE_H, STORE_B.
  - Load funct3 codes LB, LH, LW, LBU, LHU.
  - The LOAD and STORE opcodes.
  - State encoding.
- One sub-module, mem_lane_align (combinational), covers mask/shift for write lanes and extract/extend for load data. The FSM, counter and registers stay in mem_access_ctrl.

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, ack on first cycle:
  - mem_addr=0x100, be=1111, mem_wdata=0xDEADBEEF.
  - done at start+2; fault=0.
- SB addr=0x203, wdata=0x000000A5:
  - Single beat: be=1000, mem_wdata=0xA5000000.
- LH addr=0x303, beat0 rdata=0x80FFFFFF, beat1 rdata=0x000000FF:
  - Two beats, addr 0x300 with be=1000, then 0x304 with be=0001.
  - rdata=0xFFFFFF80, done at start+3.
- LBU addr=0x1, mem_rdata=0x0000F000, ack after 3 wait cycles:
  - rdata=0x000000F0, done at start+5.
  - Second start asserted during busy is ignored.
- LW with ack never given, MAX_WAIT=15:
  - mem_req high 15 cycles, then drops.
  - done=1, fault=1, rdata=0; next start accepted.
- reset_n low during BEAT1 of a misaligned SW at addr 0xFFFFFFFE:
  - BEAT0 addr=0xFFFFFFFC, BEAT1 addr=0x00000000.
  - On reset, mem_req=0 immediately, no done, state IDLE.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_ctrl_pkg
//   Shared codes for the data-memory access controller: access direction,
//   store size codes, load funct3 codes, pipeline opcodes, FSM state
//   encoding and the helper that turns a request into a byte count.
package mem_access_ctrl_pkg;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  // Store size codes follow the RISC-V store funct3[1:0]; 2'b11 falls into word.
  localparam logic [1:0] STORE_B = 2'b00;
  localparam logic [1:0] STORE_H = 2'b01;
  localparam logic [1:0] STORE_W = 2'b10;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BEAT0 = 2'b01,
    BEAT1 = 2'b10
  } state_t;

  // Access size in bytes (1, 2 or 4); unlisted codes behave as a word.
  function automatic logic [2:0] accessBytes(input logic rw,
                                             input logic [1:0] storeSel,
                                             input logic [2:0] loadSel);
    logic [2:0] bytes;
    bytes = 3'd4;
    if (rw == MEM_WRITE) begin
      case (storeSel)
        STORE_B: bytes = 3'd1;
        STORE_H: bytes = 3'd2;
        default: bytes = 3'd4;
      endcase
    end else begin
      case (loadSel)
        LB, LBU: bytes = 3'd1;
        LH, LHU: bytes = 3'd2;
        default: bytes = 3'd4;
      endcase
    end
    return bytes;
  endfunction

  // funct3[2]=0 selects the sign-extending loads.
  function automatic logic isSignedLoad(input logic [2:0] loadSel);
    return ~loadSel[2];
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align
//   Purely combinational lane steering for one access.
//   i_offset      byte offset inside the first word (addr[1:0])
//   i_sizeBytes   access size in bytes (1, 2, 4)
//   i_signed      sign-extend the load result
//   i_wdata       right-justified store data
//   i_beat0/1     read words of the first and second beat
//   o_be0/o_be1   byte enables for beat 0 / beat 1
//   o_wdata0/1    lane-aligned write data for beat 0 / beat 1
//   o_split       access crosses a word boundary and needs two beats
//   o_loadData    extracted and extended load result
module mem_lane_align
  import mem_access_ctrl_pkg::*;
(
  input  logic [1:0]  i_offset,
  input  logic [2:0]  i_sizeBytes,
  input  logic        i_signed,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_beat0,
  input  logic [31:0] i_beat1,
  output logic [3:0]  o_be0,
  output logic [3:0]  o_be1,
  output logic [31:0] o_wdata0,
  output logic [31:0] o_wdata1,
  output logic        o_split,
  output logic [31:0] o_loadData
);

  logic [7:0]  w_baseMask;
  logic [7:0]  w_mask8;
  logic [63:0] w_data64;
  logic [31:0] w_shifted;

  always_comb begin
    w_baseMask = 8'h0F;
    case (i_sizeBytes)
      3'd1:    w_baseMask = 8'h01;
      3'd2:    w_baseMask = 8'h03;
      default: w_baseMask = 8'h0F;
    endcase

    w_mask8  = w_baseMask << i_offset;
    w_data64 = {32'd0, i_wdata} << {i_offset, 3'b000};
    // Only the low word of the shifted pair can hold the result.
    w_shifted = 32'({i_beat1, i_beat0} >> {i_offset, 3'b000});

    o_be0    = w_mask8[3:0];
    o_be1    = w_mask8[7:4];
    o_wdata0 = w_data64[31:0];
    o_wdata1 = w_data64[63:32];
    o_split  = ({2'b00, i_offset} + {1'b0, i_sizeBytes}) > 4'd4;

    o_loadData = w_shifted;
    case (i_sizeBytes)
      3'd1:    o_loadData = i_signed ? {{24{w_shifted[7]}}, w_shifted[7:0]}
                                     : {24'd0, w_shifted[7:0]};
      3'd2:    o_loadData = i_signed ? {{16{w_shifted[15]}}, w_shifted[15:0]}
                                     : {16'd0, w_shifted[15:0]};
      default: o_loadData = w_shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Sequences one load/store per MEM-stage request over a req/ack word port,
//   splitting word-crossing accesses into two beats. All outputs registered.
//   i_clock, i_reset_n            clock, async active-low reset
//   i_start, i_rw                 request strobe (sampled in IDLE), direction
//   i_store_sel, i_load_sel       store size code, load funct3
//   i_addr, i_wdata               byte address, right-justified store data
//   o_busy, o_done, o_fault       stall, completion pulse, timeout flag
//   o_rdata                       extended load result (valid with o_done)
//   o_mem_req/we/addr/wdata/be    memory beat request
//   i_mem_ack, i_mem_rdata        memory beat completion and read word
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_start,
  input  logic        i_rw,
  input  logic [1:0]  i_store_sel,
  input  logic [2:0]  i_load_sel,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_fault,
  output logic [31:0] o_rdata,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_be,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata
);

  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT - 1);

  state_t      r_state;
  logic [7:0]  r_waitCnt;
  logic        r_rw;
  logic [2:0]  r_sizeBytes;
  logic        r_signed;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_beat0;
  logic        r_busy, r_done, r_fault, r_memReq, r_memWe;
  logic [31:0] r_rdata, r_memAddr, r_memWdata;
  logic [3:0]  r_memBe;

  logic [1:0]  w_alOffset;
  logic [2:0]  w_alSize;
  logic        w_alSigned;
  logic [31:0] w_alWdata, w_alBeat0, w_alBeat1;
  logic [3:0]  w_be0, w_be1;
  logic [31:0] w_wdata0, w_wdata1, w_loadData;
  logic        w_split;
  logic        w_timeout;

  // In IDLE the aligner sees the incoming request so beat-0 lanes can be
  // registered on the accepting edge; afterwards it sees the latched copy.
  // The live read word feeds whichever beat is currently being acked.
  always_comb begin
    w_alOffset = (r_state == IDLE) ? i_addr[1:0] : r_addr[1:0];
    w_alSize   = (r_state == IDLE) ? accessBytes(i_rw, i_store_sel, i_load_sel)
                                   : r_sizeBytes;
    w_alSigned = (r_state == IDLE) ? isSignedLoad(i_load_sel) : r_signed;
    w_alWdata  = (r_state == IDLE) ? i_wdata : r_wdata;
    w_alBeat0  = (r_state == BEAT0) ? i_mem_rdata : r_beat0;
    w_alBeat1  = (r_state == BEAT1) ? i_mem_rdata : 32'd0;
    // An ack arriving in the last allowed wait cycle still wins.
    w_timeout  = ~i_mem_ack && (r_waitCnt == WAIT_LIMIT);
  end

  mem_lane_align u_align (
    .i_offset    (w_alOffset),
    .i_sizeBytes (w_alSize),
    .i_signed    (w_alSigned),
    .i_wdata     (w_alWdata),
    .i_beat0     (w_alBeat0),
    .i_beat1     (w_alBeat1),
    .o_be0       (w_be0),
    .o_be1       (w_be1),
    .o_wdata0    (w_wdata0),
    .o_wdata1    (w_wdata1),
    .o_split     (w_split),
    .o_loadData  (w_loadData)
  );

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= IDLE;
      r_waitCnt   <= 8'd0;
      r_rw        <= 1'b0;
      r_sizeBytes <= 3'd0;
      r_signed    <= 1'b0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_beat0     <= 32'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_fault     <= 1'b0;
      r_rdata     <= 32'd0;
      r_memReq    <= 1'b0;
      r_memWe     <= 1'b0;
      r_memAddr   <= 32'd0;
      r_memWdata  <= 32'd0;
      r_memBe     <= 4'd0;
    end else begin
      r_done  <= 1'b0;
      r_fault <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state     <= BEAT0;
            r_waitCnt   <= 8'd0;
            r_rw        <= i_rw;
            r_sizeBytes <= w_alSize;
            r_signed    <= w_alSigned;
            r_addr      <= i_addr;
            r_wdata     <= i_wdata;
            r_busy      <= 1'b1;
            r_memReq    <= 1'b1;
            r_memWe     <= i_rw;
            r_memAddr   <= {i_addr[31:2], 2'b00};
            r_memWdata  <= w_wdata0;
            r_memBe     <= w_be0;
          end
        end
        BEAT0, BEAT1: begin
          if (i_mem_ack && (r_state == BEAT0) && w_split) begin
            // Second beat follows immediately; base+4 wraps at 2^32.
            r_state    <= BEAT1;
            r_waitCnt  <= 8'd0;
            r_beat0    <= i_mem_rdata;
            r_memAddr  <= {r_addr[31:2] + 30'd1, 2'b00};
            r_memWdata <= w_wdata1;
            r_memBe    <= w_be1;
          end else if (i_mem_ack || w_timeout) begin
            r_state  <= IDLE;
            r_waitCnt <= 8'd0;
            r_busy   <= 1'b0;
            r_memReq <= 1'b0;
            r_memWe  <= 1'b0;
            r_memBe  <= 4'd0;
            r_done   <= 1'b1;
            r_fault  <= ~i_mem_ack;
            r_rdata  <= (i_mem_ack && (r_rw == MEM_READ)) ? w_loadData : 32'd0;
          end else begin
            r_waitCnt <= r_waitCnt + 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_fault     = r_fault;
  assign o_rdata     = r_rdata;
  assign o_mem_req   = r_memReq;
  assign o_mem_we    = r_memWe;
  assign o_mem_addr  = r_memAddr;
  assign o_mem_wdata = r_memWdata;
  assign o_mem_be    = r_memBe;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl
//   Directed bench for mem_access_ctrl: every memory response is driven by
//   hand and every expected value is hand-computed from the access rules.
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        rw = 1'b0;
  logic [1:0]  storeSel = 2'b00;
  logic [2:0]  loadSel = 3'b000;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        busy, done, fault;
  logic [31:0] rdata;
  logic        memReq, memWe;
  logic [31:0] memAddr, memWdata;
  logic [3:0]  memBe;
  logic        memAck = 1'b0;
  logic [31:0] memRdata = 32'd0;

  int checkCount = 0;
  int failCount = 0;
  int reqCycles;

  mem_access_ctrl #(.MAX_WAIT(15)) dut (
    .i_clock     (clock),
    .i_reset_n   (reset_n),
    .i_start     (start),
    .i_rw        (rw),
    .i_store_sel (storeSel),
    .i_load_sel  (loadSel),
    .i_addr      (addr),
    .i_wdata     (wdata),
    .o_busy      (busy),
    .o_done      (done),
    .o_fault     (fault),
    .o_rdata     (rdata),
    .o_mem_req   (memReq),
    .o_mem_we    (memWe),
    .o_mem_addr  (memAddr),
    .o_mem_wdata (memWdata),
    .o_mem_be    (memBe),
    .i_mem_ack   (memAck),
    .i_mem_rdata (memRdata)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Called at a falling edge: holds start for one rising edge, returns at
  // the next falling edge, i.e. in the first BEAT0 cycle.
  task automatic applyStimulus(input logic isWrite, input logic [1:0] sSel,
                               input logic [2:0] lSel, input logic [31:0] a,
                               input logic [31:0] d);
    rw = isWrite;
    storeSel = sSel;
    loadSel = lSel;
    addr = a;
    wdata = d;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clock);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_fault", {31'd0, fault}, 32'd0);
    checkOutput("rst_rdata", rdata, 32'd0);
    checkOutput("rst_req", {31'd0, memReq}, 32'd0);
    checkOutput("rst_we", {31'd0, memWe}, 32'd0);
    checkOutput("rst_addr", memAddr, 32'd0);
    checkOutput("rst_wdata", memWdata, 32'd0);
    checkOutput("rst_be", {28'd0, memBe}, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // Stray ack while idle must do nothing.
    memAck = 1'b1;
    @(negedge clock);
    memAck = 1'b0;
    checkOutput("idleack_busy", {31'd0, busy}, 32'd0);
    checkOutput("idleack_done", {31'd0, done}, 32'd0);

    // SW 0x100, ack in first cycle, done at start+2.
    applyStimulus(MEM_WRITE, STORE_W, LW, 32'h0000_0100, 32'hDEAD_BEEF);
    checkOutput("sw_busy", {31'd0, busy}, 32'd1);
    checkOutput("sw_req", {31'd0, memReq}, 32'd1);
    checkOutput("sw_we", {31'd0, memWe}, 32'd1);
    checkOutput("sw_addr", memAddr, 32'h0000_0100);
    checkOutput("sw_be", {28'd0, memBe}, 32'h0000_000F);
    checkOutput("sw_wdata", memWdata, 32'hDEAD_BEEF);
    checkOutput("sw_done_early", {31'd0, done}, 32'd0);
    memAck = 1'b1;
    @(negedge clock);
    memAck = 1'b0;
    checkOutput("sw_done", {31'd0, done}, 32'd1);
    checkOutput("sw_fault", {31'd0, fault}, 32'd0);
    checkOutput("sw_rdata", rdata, 32'd0);
    checkOutput("sw_req_drop", {31'd0, memReq}, 32'd0);
    checkOutput("sw_busy_drop", {31'd0, busy}, 32'd0);
    @(negedge clock);
    checkOutput("sw_done_pulse", {31'd0, done}, 32'd0);

    // SB 0x203: single beat in lane 3.
    applyStimulus(MEM_WRITE, STORE_B, LB, 32'h0000_0203, 32'h0000_00A5);
    checkOutput("sb_addr", memAddr, 32'h0000_0200);
    checkOutput("sb_be", {28'd0, memBe}, 32'h0000_0008);
    checkOutput("sb_wdata", memWdata, 32'hA500_0000);
    memAck = 1'b1;
    @(negedge clock);
    memAck = 1'b0;
    checkOutput("sb_done", {31'd0, done}, 32'd1);
    checkOutput("sb_req_drop", {31'd0, memReq}, 32'd0);
    @(negedge clock);

    // LH 0x303: split across 0x300/0x304, done at start+3.
    applyStimulus(MEM_READ, STORE_W, LH, 32'h0000_0303, 32'd0);
    checkOutput("lh_we", {31'd0, memWe}, 32'd0);
    checkOutput("lh_b0_addr", memAddr, 32'h0000_0300);
    checkOutput("lh_b0_be", {28'd0, memBe}, 32'h0000_0008);
    memAck = 1'b1;
    memRdata = 32'h80FF_FFFF;
    @(negedge clock);
    checkOutput("lh_b0_done", {31'd0, done}, 32'd0);
    checkOutput("lh_b1_req", {31'd0, memReq}, 32'd1);
    checkOutput("lh_b1_addr", memAddr, 32'h0000_0304);
    checkOutput("lh_b1_be", {28'd0, memBe}, 32'h0000_0001);
    memRdata = 32'h0000_00FF;
    @(negedge clock);
    memAck = 1'b0;
    memRdata = 32'd0;
    checkOutput("lh_done", {31'd0, done}, 32'd1);
    checkOutput("lh_rdata", rdata, 32'hFFFF_FF80);
    checkOutput("lh_fault", {31'd0, fault}, 32'd0);
    @(negedge clock);

    // LBU 0x1 with three wait cycles; a second start during busy is ignored.
    applyStimulus(MEM_READ, STORE_W, LBU, 32'h0000_0001, 32'd0);
    rw = MEM_WRITE;
    storeSel = STORE_W;
    addr = 32'h0000_0500;
    wdata = 32'h1234_5678;
    start = 1'b1;
    checkOutput("lbu_addr", memAddr, 32'h0000_0000);
    checkOutput("lbu_be", {28'd0, memBe}, 32'h0000_0002);
    repeat (2) @(negedge clock);
    checkOutput("lbu_wait_req", {31'd0, memReq}, 32'd1);
    checkOutput("lbu_wait_addr", memAddr, 32'h0000_0000);
    checkOutput("lbu_wait_we", {31'd0, memWe}, 32'd0);
    checkOutput("lbu_wait_done", {31'd0, done}, 32'd0);
    @(negedge clock);
    start = 1'b0;
    memAck = 1'b1;
    memRdata = 32'h0000_F000;
    @(negedge clock);
    memAck = 1'b0;
    memRdata = 32'd0;
    checkOutput("lbu_done", {31'd0, done}, 32'd1);
    checkOutput("lbu_rdata", rdata, 32'h0000_00F0);
    @(negedge clock);
    checkOutput("lbu_no_restart", {31'd0, busy}, 32'd0);
    checkOutput("lbu_no_req", {31'd0, memReq}, 32'd0);

    // LW with no ack: 15 request cycles then fault.
    applyStimulus(MEM_READ, STORE_W, LW, 32'h0000_0400, 32'd0);
    reqCycles = 0;
    for (int i = 0; i < 20 && memReq; i++) begin
      reqCycles++;
      @(negedge clock);
    end
    checkOutput("to_req_cycles", reqCycles, 32'd15);
    checkOutput("to_req_drop", {31'd0, memReq}, 32'd0);
    checkOutput("to_done", {31'd0, done}, 32'd1);
    checkOutput("to_fault", {31'd0, fault}, 32'd1);
    checkOutput("to_rdata", rdata, 32'd0);
    // Start in the done cycle is accepted.
    applyStimulus(MEM_WRITE, STORE_H, LH, 32'h0000_0602, 32'h0000_BEEF);
    checkOutput("next_req", {31'd0, memReq}, 32'd1);
    checkOutput("next_addr", memAddr, 32'h0000_0600);
    checkOutput("next_be", {28'd0, memBe}, 32'h0000_000C);
    checkOutput("next_wdata", memWdata, 32'hBEEF_0000);
    checkOutput("next_fault_clr", {31'd0, fault}, 32'd0);
    memAck = 1'b1;
    @(negedge clock);
    memAck = 1'b0;
    checkOutput("next_done", {31'd0, done}, 32'd1);
    @(negedge clock);

    // Misaligned SW at 0xFFFFFFFE wraps to 0; reset lands in BEAT1.
    applyStimulus(MEM_WRITE, STORE_W, LW, 32'hFFFF_FFFE, 32'h1122_3344);
    checkOutput("wrap_b0_addr", memAddr, 32'hFFFF_FFFC);
    checkOutput("wrap_b0_be", {28'd0, memBe}, 32'h0000_000C);
    checkOutput("wrap_b0_wdata", memWdata, 32'h3344_0000);
    memAck = 1'b1;
    @(negedge clock);
    memAck = 1'b0;
    checkOutput("wrap_b1_addr", memAddr, 32'h0000_0000);
    checkOutput("wrap_b1_be", {28'd0, memBe}, 32'h0000_0003);
    checkOutput("wrap_b1_wdata", memWdata, 32'h0000_1122);
    checkOutput("wrap_b1_req", {31'd0, memReq}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("arst_req", {31'd0, memReq}, 32'd0);
    checkOutput("arst_busy", {31'd0, busy}, 32'd0);
    checkOutput("arst_done", {31'd0, done}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    checkOutput("post_rst_done", {31'd0, done}, 32'd0);
    checkOutput("post_rst_busy", {31'd0, busy}, 32'd0);

    // LB 0x2 after reset: controller is back in IDLE and sign-extends.
    applyStimulus(MEM_READ, STORE_W, LB, 32'h0000_0002, 32'd0);
    checkOutput("lb_be", {28'd0, memBe}, 32'h0000_0004);
    memAck = 1'b1;
    memRdata = 32'h0080_0000;
    @(negedge clock);
    memAck = 1'b0;
    memRdata = 32'd0;
    checkOutput("lb_done", {31'd0, done}, 32'd1);
    checkOutput("lb_rdata", rdata, 32'hFFFF_FF80);
    @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
